// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_lsu
// Purpose  : Memory-stage load/store unit; runs one handshaked word access per
//            RV32I load/store and stalls the pipeline until it completes.
//            Optional macro LSU_MISALIGN_TRAP_EN flags misaligned H/W accesses.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage_lsu #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_valid,
    input  logic [31:0] i_insn,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_store_data,
    output logic        o_stall,
    output logic [31:0] o_insn,
    output logic [31:0] o_ALU_O,
    output logic [31:0] o_mem_D,
    output logic        o_bus_err,
    output logic        o_misaligned,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      result_q;
    logic             mem_req_q;
    logic             mem_we_q;
    logic [31:0]      mem_addr_q;
    logic [31:0]      mem_wdata_q;
    logic [3:0]       mem_wstrb_q;
    logic [1:0]       size_q;
    logic             uns_q;
    logic [1:0]       off_q;
    logic             bus_err_q;
    logic             misaligned_q;

    logic [2:0]       funct3_d;
    logic             is_load_d;
    logic             is_store_d;
    logic             is_mem_d;
    logic             mis_d;
    logic [1:0]       off_d;
    logic [31:0]      wdata_d;
    logic [3:0]       wstrb_d;
    logic [31:0]      shifted_d;
    logic [31:0]      load_d;

    assign funct3_d = i_insn[14:12];

    always_comb begin
        is_load_d  = (i_insn[6:0] == 7'b0000011) &&
                     (funct3_d inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        is_store_d = (i_insn[6:0] == 7'b0100011) &&
                     (funct3_d inside {3'b000, 3'b001, 3'b010});
        is_mem_d   = i_valid && (is_load_d || is_store_d);

        // Offset bits below the access size never select a lane.
        case (funct3_d[1:0])
            2'b00:   off_d = i_addr[1:0];
            2'b01:   off_d = {i_addr[1], 1'b0};
            default: off_d = 2'b00;
        endcase

        case (funct3_d[1:0])
            2'b00:   wdata_d = {4{i_store_data[7:0]}};
            2'b01:   wdata_d = {2{i_store_data[15:0]}};
            default: wdata_d = i_store_data;
        endcase

        wstrb_d = 4'b0000;
        if (is_store_d) begin
            case (funct3_d[1:0])
                2'b00:   wstrb_d = 4'b0001 << off_d;
                2'b01:   wstrb_d = 4'b0011 << off_d;
                default: wstrb_d = 4'b1111;
            endcase
        end

`ifdef LSU_MISALIGN_TRAP_EN
        mis_d = ((funct3_d[1:0] == 2'b01) && i_addr[0]) ||
                ((funct3_d[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));
`else
        mis_d = 1'b0;
`endif
    end

    assign shifted_d = mem_rdata >> {off_q, 3'b000};

    always_comb begin
        case (size_q)
            2'b00:   load_d = uns_q ? {24'd0, shifted_d[7:0]}
                                    : {{24{shifted_d[7]}}, shifted_d[7:0]};
            2'b01:   load_d = uns_q ? {16'd0, shifted_d[15:0]}
                                    : {{16{shifted_d[15]}}, shifted_d[15:0]};
            default: load_d = shifted_d;
        endcase
    end

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            result_q     <= 32'd0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
            mem_wstrb_q  <= 4'd0;
            size_q       <= 2'd0;
            uns_q        <= 1'b0;
            off_q        <= 2'd0;
            bus_err_q    <= 1'b0;
            misaligned_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    misaligned_q <= 1'b0;
                    if (is_mem_d) begin
                        result_q <= 32'd0;
                        if (mis_d) begin
                            misaligned_q <= 1'b1;
                            state_q      <= S_DONE;
                        end else begin
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= is_store_d;
                            mem_addr_q  <= {i_addr[31:2], 2'b00};
                            mem_wdata_q <= wdata_d;
                            mem_wstrb_q <= wstrb_d;
                            size_q      <= funct3_d[1:0];
                            uns_q       <= funct3_d[2];
                            off_q       <= off_d;
                            cnt_q       <= '0;
                            state_q     <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    // A response on the final budget cycle still counts as success.
                    if (mem_ready) begin
                        mem_req_q <= 1'b0;
                        cnt_q     <= '0;
                        if (!mem_we_q) begin
                            result_q <= load_d;
                        end
                        state_q   <= S_DONE;
                    end else if (cnt_q == C_CNT_LAST) begin
                        mem_req_q <= 1'b0;
                        bus_err_q <= 1'b1;
                        result_q  <= 32'd0;
                        cnt_q     <= '0;
                        state_q   <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    misaligned_q <= 1'b0;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_stall      = !reset && (((state_q == S_IDLE) && is_mem_d) || (state_q == S_WAIT));
    assign o_insn       = i_insn;
    assign o_ALU_O      = i_addr;
    assign o_mem_D      = (state_q == S_DONE) ? result_q : 32'd0;
    assign o_bus_err    = bus_err_q;
    assign o_misaligned = misaligned_q;
    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_wstrb    = mem_wstrb_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage_lsu
// Purpose  : Self-checking bench for mem_stage_lsu against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage_lsu;
    localparam int TIMEOUT = 64;

    logic        clock;
    logic        reset;
    logic        i_valid;
    logic [31:0] i_insn, i_addr, i_store_data;
    logic        o_stall, o_bus_err, o_misaligned;
    logic [31:0] o_insn, o_ALU_O, o_mem_D;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    int errors = 0;
    int checks = 0;

    mem_stage_lsu #(.TIMEOUT(TIMEOUT), .CNT_W(7)) dut (
        .clock(clock), .reset(reset), .i_valid(i_valid), .i_insn(i_insn),
        .i_addr(i_addr), .i_store_data(i_store_data), .o_stall(o_stall),
        .o_insn(o_insn), .o_ALU_O(o_ALU_O), .o_mem_D(o_mem_D),
        .o_bus_err(o_bus_err), .o_misaligned(o_misaligned), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got hang, required completion");
        $fatal(1);
    end

    function automatic logic [31:0] mk(input int f3, input int opc);
        return 32'((f3 << 12) | (5 << 7) | opc);
    endfunction

    // Reference: what one access should look like, from the ISA rules.
    function automatic void model(input logic [31:0] insn, addr, sdata, rdata,
                                  output bit is_mem, output bit is_st, output bit mis,
                                  output logic [31:0] e_addr, output logic [31:0] e_wdata,
                                  output logic [3:0] e_wstrb, output logic [31:0] e_memd);
        int     f3;
        int     nb;
        int     off;
        bit     sgn;
        longint v;
        f3 = int'(insn[14:12]);
        is_mem = 0; is_st = 0; mis = 0;
        e_addr = 0; e_wdata = 0; e_wstrb = 0; e_memd = 0;
        if (insn[6:0] == 7'h03 && (f3 inside {0, 1, 2, 4, 5})) is_mem = 1;
        else if (insn[6:0] == 7'h23 && f3 <= 2) begin is_mem = 1; is_st = 1; end
        if (!is_mem) return;
        nb  = 1 << (f3 % 4);
        sgn = (f3 < 4);
        off = int'(addr % 4);
`ifdef LSU_MISALIGN_TRAP_EN
        mis = (off % nb) != 0;
`endif
        off = off - (off % nb);
        if (mis) return;
        e_addr = addr & ~32'd3;
        if (is_st) begin
            e_wstrb = 4'(((1 << nb) - 1) << off);
            if (nb == 4)      e_wdata = sdata;
            else if (nb == 2) e_wdata = 32'((sdata % 65536) * 65537);
            else              e_wdata = 32'((sdata % 256) * 32'h01010101);
        end else begin
            v = (longint'(rdata) >> (8 * off)) % (longint'(1) << (8 * nb));
            if (sgn && nb < 4 && v >= (longint'(1) << (8 * nb - 1)))
                v = v - (longint'(1) << (8 * nb));
            e_memd = v[31:0];
        end
    endfunction

    // Drives one instruction and plays the memory; returns what was observed.
    task automatic xact(input logic [31:0] insn, addr, sdata, rdata, input int delay,
                        input bit no_sync, output int stalls, output bit req_seen,
                        output logic [31:0] c_addr, output logic [31:0] c_wdata,
                        output logic [3:0] c_wstrb, output logic c_we, output bit stable,
                        output bit pass_ok, output logic [31:0] memd, output logic mis,
                        output logic err, output bit finished);
        int wcyc;
        if (!no_sync) begin
            @(negedge clock); #1;
        end
        i_valid = 1'b1; i_insn = insn; i_addr = addr; i_store_data = sdata;
        stalls = 0; req_seen = 0; stable = 1; finished = 0; pass_ok = 1; wcyc = 0;
        c_addr = 0; c_wdata = 0; c_wstrb = 0; c_we = 0; memd = 0; mis = 0; err = 0;
        for (int c = 0; c < TIMEOUT + 20 && !finished; c++) begin
            @(posedge clock);
            if (o_insn !== insn || o_ALU_O !== addr) pass_ok = 0;
            if (o_stall === 1'b1) begin
                stalls++;
                if (mem_req === 1'b1) begin
                    if (!req_seen) begin
                        req_seen = 1; c_addr = mem_addr; c_wdata = mem_wdata;
                        c_wstrb = mem_wstrb; c_we = mem_we;
                    end else if (mem_addr !== c_addr || mem_wdata !== c_wdata ||
                                 mem_wstrb !== c_wstrb || mem_we !== c_we) begin
                        stable = 0;
                    end
                    if (wcyc == delay) begin mem_ready = 1'b1; mem_rdata = rdata; end
                    wcyc++;
                end
            end else begin
                finished = 1; memd = o_mem_D; mis = o_misaligned; err = o_bus_err;
            end
            @(negedge clock); #1;
            mem_ready = 1'b0; mem_rdata = $urandom;
            if (finished) i_valid = 1'b0;
        end
    endtask

    // Shared observation variables for the scenario tasks.
    int          s_stalls;
    bit          s_req, s_stable, s_pass, s_fin;
    logic [31:0] s_addr, s_wdata, s_memd;
    logic [3:0]  s_wstrb;
    logic        s_we, s_mis, s_err;

    task automatic test_reset();
        checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin errors++;
            $display("FAIL reset_req: got req=%b we=%b, required 0 0", mem_req, mem_we); end
        checks++; if (mem_addr !== 32'd0 || mem_wdata !== 32'd0 || mem_wstrb !== 4'd0) begin errors++;
            $display("FAIL reset_bus: got addr=%h wdata=%h wstrb=%b, required zeros", mem_addr, mem_wdata, mem_wstrb); end
        checks++; if (o_stall !== 1'b0 || o_bus_err !== 1'b0 || o_misaligned !== 1'b0 || o_mem_D !== 32'd0) begin errors++;
            $display("FAIL reset_outs: got stall=%b err=%b mis=%b memd=%h, required zeros", o_stall, o_bus_err, o_misaligned, o_mem_D); end
    endtask

    task automatic test_ignore_ready();
        @(negedge clock); #1;
        i_valid = 1'b0; mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        repeat (3) begin
            @(posedge clock);
            checks++; if (o_stall !== 1'b0 || mem_req !== 1'b0 || o_mem_D !== 32'd0) begin errors++;
                $display("FAIL idle_ready: got stall=%b req=%b memd=%h, required 0 0 0", o_stall, mem_req, o_mem_D); end
        end
        @(negedge clock); #1; mem_ready = 1'b0;
        xact(mk(0, 7'h13), 32'h1000, 0, 0, 0, 0, s_stalls, s_req, s_addr, s_wdata, s_wstrb,
             s_we, s_stable, s_pass, s_memd, s_mis, s_err, s_fin);
        checks++; if (s_stalls != 0 || s_req || s_memd !== 32'd0) begin errors++;
            $display("FAIL non_mem: got stalls=%0d req=%0d memd=%h, required 0 0 0", s_stalls, s_req, s_memd); end
    endtask

    typedef struct {
        logic [31:0] insn, addr, sdata, rdata, e_addr, e_wdata, e_memd;
        logic [3:0]  e_wstrb;
        logic        e_we;
    } vec_t;

    task automatic test_directed();
        vec_t v[8];
        v[0] = '{mk(2, 7'h03), 32'h1004, 32'h0, 32'hDEADBEEF, 32'h1004, 32'h0, 32'hDEADBEEF, 4'b0000, 1'b0};
        v[1] = '{mk(0, 7'h03), 32'h1003, 32'h0, 32'h80FF0000, 32'h1000, 32'h0, 32'hFFFFFF80, 4'b0000, 1'b0};
        v[2] = '{mk(4, 7'h03), 32'h1003, 32'h0, 32'h80FF0000, 32'h1000, 32'h0, 32'h00000080, 4'b0000, 1'b0};
        v[3] = '{mk(1, 7'h03), 32'h1002, 32'h0, 32'h80FF0000, 32'h1000, 32'h0, 32'hFFFF80FF, 4'b0000, 1'b0};
        v[4] = '{mk(0, 7'h23), 32'h2001, 32'h123456AB, 32'h0, 32'h2000, 32'hABABABAB, 32'h0, 4'b0010, 1'b1};
        v[5] = '{mk(1, 7'h23), 32'h2002, 32'h0000CAFE, 32'h0, 32'h2000, 32'hCAFECAFE, 32'h0, 4'b1100, 1'b1};
        v[6] = '{mk(2, 7'h23), 32'h3000, 32'h11223344, 32'h0, 32'h3000, 32'h11223344, 32'h0, 4'b1111, 1'b1};
        v[7] = '{mk(5, 7'h03), 32'h1000, 32'h0, 32'h00008001, 32'h1000, 32'h0, 32'h00008001, 4'b0000, 1'b0};
        for (int i = 0; i < 8; i++) begin
            xact(v[i].insn, v[i].addr, v[i].sdata, v[i].rdata, 0, 0, s_stalls, s_req, s_addr,
                 s_wdata, s_wstrb, s_we, s_stable, s_pass, s_memd, s_mis, s_err, s_fin);
            checks++; if (s_stalls != 2 || !s_req || !s_fin) begin errors++;
                $display("FAIL dir%0d_timing: got stalls=%0d req=%0d done=%0d, required 2 1 1", i, s_stalls, s_req, s_fin); end
            checks++; if (s_addr !== v[i].e_addr || s_we !== v[i].e_we || s_wstrb !== v[i].e_wstrb) begin errors++;
                $display("FAIL dir%0d_bus: got addr=%h we=%b wstrb=%b, required %h %b %b", i, s_addr, s_we, s_wstrb, v[i].e_addr, v[i].e_we, v[i].e_wstrb); end
            if (v[i].e_we) begin
                checks++; if (s_wdata !== v[i].e_wdata) begin errors++;
                    $display("FAIL dir%0d_wdata: got %h, required %h", i, s_wdata, v[i].e_wdata); end
            end
            checks++; if (s_memd !== v[i].e_memd || !s_pass) begin errors++;
                $display("FAIL dir%0d_memd: got memd=%h pass=%0d, required %h 1", i, s_memd, s_pass, v[i].e_memd); end
        end
    endtask

    task automatic test_misalign();
        xact(mk(2, 7'h03), 32'h1002, 0, 32'hDEADBEEF, 0, 0, s_stalls, s_req, s_addr, s_wdata,
             s_wstrb, s_we, s_stable, s_pass, s_memd, s_mis, s_err, s_fin);
`ifdef LSU_MISALIGN_TRAP_EN
        checks++; if (s_req || s_stalls != 1 || s_mis !== 1'b1 || s_memd !== 32'd0) begin errors++;
            $display("FAIL misalign_trap: got req=%0d stalls=%0d mis=%b memd=%h, required 0 1 1 0", s_req, s_stalls, s_mis, s_memd); end
        @(posedge clock);
        checks++; if (o_misaligned !== 1'b0) begin errors++;
            $display("FAIL misalign_pulse: got %b after DONE, required 0", o_misaligned); end
`else
        checks++; if (!s_req || s_addr !== 32'h1000 || s_wstrb !== 4'b0000 || s_memd !== 32'hDEADBEEF || s_mis !== 1'b0) begin errors++;
            $display("FAIL misalign_pass: got req=%0d addr=%h wstrb=%b memd=%h mis=%b, required 1 1000 0000 deadbeef 0", s_req, s_addr, s_wstrb, s_memd, s_mis); end
`endif
    endtask

    task automatic test_back_to_back();
        xact(mk(2, 7'h03), 32'h4000, 0, 32'h01234567, 1, 0, s_stalls, s_req, s_addr, s_wdata,
             s_wstrb, s_we, s_stable, s_pass, s_memd, s_mis, s_err, s_fin);
        checks++; if (s_stalls != 3 || s_memd !== 32'h01234567) begin errors++;
            $display("FAIL b2b_first: got stalls=%0d memd=%h, required 3 01234567", s_stalls, s_memd); end
        xact(mk(0, 7'h23), 32'h4003, 32'h000000C3, 0, 0, 1, s_stalls, s_req, s_addr, s_wdata,
             s_wstrb, s_we, s_stable, s_pass, s_memd, s_mis, s_err, s_fin);
        checks++; if (s_stalls != 2 || s_wstrb !== 4'b1000 || s_wdata !== 32'hC3C3C3C3 || s_memd !== 32'd0) begin errors++;
            $display("FAIL b2b_second: got stalls=%0d wstrb=%b wdata=%h memd=%h, required 2 1000 c3c3c3c3 0", s_stalls, s_wstrb, s_wdata, s_memd); end
    endtask

    task automatic test_random();
        bit          m_mem, m_st, m_mis;
        logic [31:0] e_addr, e_wdata, e_memd, insn, addr, sdata, rdata;
        logic [3:0]  e_wstrb;
        int          dly, e_stalls;
        for (int n = 0; n < 40; n++) begin
            insn = $urandom;
            case ($urandom_range(0, 4))
                0, 1:    insn[6:0] = 7'h03;
                2, 3:    insn[6:0] = 7'h23;
                default: insn[6:0] = 7'h33;
            endcase
            addr = $urandom; sdata = $urandom; rdata = $urandom;
            dly = $urandom_range(0, 4);
            model(insn, addr, sdata, rdata, m_mem, m_st, m_mis, e_addr, e_wdata, e_wstrb, e_memd);
            e_stalls = !m_mem ? 0 : (m_mis ? 1 : 2 + dly);
            xact(insn, addr, sdata, rdata, dly, 0, s_stalls, s_req, s_addr, s_wdata, s_wstrb,
                 s_we, s_stable, s_pass, s_memd, s_mis, s_err, s_fin);
            checks++; if (s_stalls != e_stalls || s_req != (m_mem && !m_mis) || !s_stable || !s_pass) begin errors++;
                $display("FAIL rnd%0d_flow: insn=%h got stalls=%0d req=%0d stable=%0d pass=%0d, required %0d %0d 1 1",
                         n, insn, s_stalls, s_req, s_stable, s_pass, e_stalls, m_mem && !m_mis); end
            if (s_req) begin
                checks++; if (s_addr !== e_addr || s_we !== m_st || s_wstrb !== e_wstrb || (m_st && s_wdata !== e_wdata)) begin errors++;
                    $display("FAIL rnd%0d_bus: insn=%h addr=%h got %h %b %b %h, required %h %b %b %h",
                             n, insn, addr, s_addr, s_we, s_wstrb, s_wdata, e_addr, m_st, e_wstrb, e_wdata); end
            end
            checks++; if (s_memd !== e_memd || s_mis !== m_mis) begin errors++;
                $display("FAIL rnd%0d_memd: insn=%h addr=%h rdata=%h got memd=%h mis=%b, required %h %b",
                         n, insn, addr, rdata, s_memd, s_mis, e_memd, m_mis); end
        end
    endtask

    task automatic test_timeout();
        xact(mk(2, 7'h03), 32'h5000, 0, 0, -1, 0, s_stalls, s_req, s_addr, s_wdata, s_wstrb,
             s_we, s_stable, s_pass, s_memd, s_mis, s_err, s_fin);
        checks++; if (!s_fin || s_stalls != TIMEOUT + 1) begin errors++;
            $display("FAIL timeout_len: got stalls=%0d done=%0d, required %0d 1", s_stalls, s_fin, TIMEOUT + 1); end
        checks++; if (s_err !== 1'b1 || s_memd !== 32'd0 || mem_req !== 1'b0) begin errors++;
            $display("FAIL timeout_err: got err=%b memd=%h req=%b, required 1 0 0", s_err, s_memd, mem_req); end
        xact(mk(2, 7'h03), 32'h5004, 0, 32'h55AA55AA, 0, 0, s_stalls, s_req, s_addr, s_wdata,
             s_wstrb, s_we, s_stable, s_pass, s_memd, s_mis, s_err, s_fin);
        checks++; if (s_err !== 1'b1 || s_memd !== 32'h55AA55AA || s_stalls != 2) begin errors++;
            $display("FAIL timeout_sticky: got err=%b memd=%h stalls=%0d, required 1 55aa55aa 2", s_err, s_memd, s_stalls); end
    endtask

    task automatic test_reset_midwait();
        @(negedge clock); #1;
        i_valid = 1'b1; i_insn = mk(2, 7'h03); i_addr = 32'h6000;
        repeat (4) @(posedge clock);
        checks++; if (mem_req !== 1'b1 || o_stall !== 1'b1) begin errors++;
            $display("FAIL midwait_pre: got req=%b stall=%b, required 1 1", mem_req, o_stall); end
        #2 reset = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0 || o_stall !== 1'b0 || o_bus_err !== 1'b0) begin errors++;
            $display("FAIL midwait_reset: got req=%b stall=%b err=%b, required 0 0 0", mem_req, o_stall, o_bus_err); end
        i_valid = 1'b0;
        @(posedge clock); reset = 1'b0;
        xact(mk(2, 7'h03), 32'h6008, 0, 32'hCAFEF00D, 0, 0, s_stalls, s_req, s_addr, s_wdata,
             s_wstrb, s_we, s_stable, s_pass, s_memd, s_mis, s_err, s_fin);
        checks++; if (s_stalls != 2 || s_memd !== 32'hCAFEF00D || s_addr !== 32'h6008 || s_err !== 1'b0) begin errors++;
            $display("FAIL midwait_after: got stalls=%0d memd=%h addr=%h err=%b, required 2 cafef00d 6008 0", s_stalls, s_memd, s_addr, s_err); end
    endtask

    initial begin
        reset = 1'b1; i_valid = 1'b0; i_insn = 32'd0; i_addr = 32'd0;
        i_store_data = 32'd0; mem_ready = 1'b0; mem_rdata = 32'd0;
        #12;
        test_reset();
        #11 reset = 1'b0;
        #1;
        test_reset();
        test_ignore_ready();
        test_directed();
        test_misalign();
        test_back_to_back();
        test_random();
        test_timeout();
        test_reset_midwait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
